// File: rtl/ex_divider.sv
// ex_divider: multi-cycle radix-2 restoring divider for the EX stage.
// Handles div.w / mod.w / div.wu / mod.wu and produces one quotient bit per
// cycle. It talks to EX through a ready/done handshake and a pipeline flush
// can cancel it.
module ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_valid,
    input  logic [3:0]       div_op,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_flush,
    output logic             div_ready,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    // Dividend bits shift out of the top of this register while quotient
    // bits shift in at the bottom. After WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] partial_rem;
    logic [WIDTH-1:0] divisor_mag;
    logic             quot_neg;
    logic             rem_neg;
    logic             want_rem;
    logic             div_by_zero;
    logic [WIDTH-1:0] raw_src1;

    // Decoded request fields. The signed ops work on magnitudes. A quotient
    // opcode bit takes precedence, so every opcode bit has a defined role.
    logic             op_signed;
    logic             op_rem;
    logic [WIDTH-1:0] src1_mag;
    logic [WIDTH-1:0] src2_mag;

    // Datapath for one restoring step and the final sign fix-up.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             quot_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;
    logic [WIDTH-1:0] result_next;

    // Decode the incoming request into signedness, op select and magnitudes.
    always_comb begin
        op_signed = div_op[0] | div_op[1];
        op_rem    = (div_op[1] | div_op[3]) & ~(div_op[0] | div_op[2]);
        src1_mag  = div_src1;
        src2_mag  = div_src2;
        if (op_signed && div_src1[WIDTH-1]) begin
            src1_mag = -div_src1;
        end
        if (op_signed && div_src2[WIDTH-1]) begin
            src2_mag = -div_src2;
        end
    end

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // The partial remainder is always below the divisor, so the extra top bit
    // of the WIDTH+1 bit difference is a reliable borrow flag.
    always_comb begin
        rem_shift   = {partial_rem, dividend[WIDTH-1]};
        trial       = rem_shift - {1'b0, divisor_mag};
        quot_bit    = ~trial[WIDTH];
        rem_next    = quot_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quot_next   = {dividend[WIDTH-2:0], quot_bit};
        quot_final  = quot_neg ? -quot_next : quot_next;
        rem_final   = rem_neg ? -rem_next : rem_next;
        result_next = want_rem ? rem_final : quot_final;
        if (div_by_zero) begin
            result_next = want_rem ? raw_src1 : {WIDTH{1'b1}};
        end
    end

    // Control FSM with registered handshake outputs and the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dividend    <= '0;
            partial_rem <= '0;
            divisor_mag <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            want_rem    <= 1'b0;
            div_by_zero <= 1'b0;
            raw_src1    <= '0;
            div_ready   <= 1'b1;
            div_done    <= 1'b0;
            div_result  <= '0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_valid && !div_flush) begin
                        dividend    <= src1_mag;
                        divisor_mag <= src2_mag;
                        partial_rem <= '0;
                        count       <= '0;
                        quot_neg    <= op_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                        rem_neg     <= op_signed & div_src1[WIDTH-1];
                        want_rem    <= op_rem;
                        div_by_zero <= (div_src2 == '0);
                        raw_src1    <= div_src1;
                        div_ready   <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    if (div_flush) begin
                        count     <= '0;
                        div_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        partial_rem <= rem_next;
                        dividend    <= quot_next;
                        if (count == LAST) begin
                            count      <= '0;
                            div_done   <= 1'b1;
                            div_result <= result_next;
                            state      <= DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                DONE: begin
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    count     <= '0;
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed-vector bench for ex_divider. It combines a
// cycle-level reference model with hand-computed literal results.
module tb_ex_divider;

    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_MOD  = 4'b0010;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_MODU = 4'b1000;
    localparam int         LAT     = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_valid = 1'b0;
    logic [3:0]  div_op = 4'b0;
    logic [31:0] div_src1 = '0;
    logic [31:0] div_src2 = '0;
    logic        div_flush = 1'b0;
    logic        div_ready;
    logic        div_done;
    logic [31:0] div_result;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    // Reference model state.
    int          m_since = 0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        exp_ready = 1'b1;
    logic        exp_done = 1'b0;
    logic [31:0] exp_result = '0;

    ex_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_flush  (div_flush),
        .div_ready  (div_ready),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    // Architectural result of a LoongArch divide, straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op[0] | op[2]) ? 32'hFFFF_FFFF : a;
        if (op[0] | op[1]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'h8000_0000 : 32'd0;
            return op[0] ? 32'(sa / sb) : 32'(sa % sb);
        end
        return op[2] ? (a / b) : (a % b);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Model: an accepted op completes LAT cycles later unless it is flushed.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_since    = 0;
            exp_ready  = 1'b1;
            exp_done   = 1'b0;
            exp_result = '0;
        end else if (m_since == 0) begin
            if (div_valid && !div_flush) begin
                m_since   = 1;
                m_op      = div_op;
                m_a       = div_src1;
                m_b       = div_src2;
                exp_ready = 1'b0;
            end
        end else if (m_since < LAT) begin
            if (div_flush) begin
                m_since   = 0;
                exp_ready = 1'b1;
            end else begin
                m_since++;
                if (m_since == LAT) begin
                    exp_done   = 1'b1;
                    exp_result = ref_div(m_op, m_a, m_b);
                end
            end
        end else begin
            m_since   = 0;
            exp_done  = 1'b0;
            exp_ready = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cmp_ready", {31'b0, div_ready}, {31'b0, exp_ready});
            checkOutput("cmp_done", {31'b0, div_done}, {31'b0, exp_done});
            checkOutput("cmp_result", div_result, exp_result);
        end
    end

    // Present one request for a single cycle. Returns on the negedge after accept.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_valid = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
        @(negedge clk);
        div_valid = 1'b0;
    endtask

    // Run one operation and check the handshake timing and the literal result.
    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
        int lat;
        applyStimulus(op, a, b);
        checkOutput({name, "_ready_drop"}, {31'b0, div_ready}, 32'd0);
        lat = 1;
        while (!div_done && lat < LAT + 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
        checkOutput({name, "_result"}, div_result, want);
        @(negedge clk);
        checkOutput({name, "_ready_back"}, {31'b0, div_ready}, 32'd1);
        checkOutput({name, "_done_pulse"}, {31'b0, div_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {31'b0, div_ready}, 32'd1);
        checkOutput("reset_done", {31'b0, div_done}, 32'd0);
        checkOutput("reset_result", div_result, 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        runOp("divw_100_7", OP_DIV, 32'd100, 32'd7, 32'd14);
        runOp("divw_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runOp("modw_m7_2", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runOp("divwu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        runOp("modwu_max_16", OP_MODU, 32'hFFFF_FFFF, 32'h10, 32'hF);
        runOp("divw_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runOp("modw_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        runOp("modw_7_m2", OP_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1);
        runOp("divw_dbz", OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        runOp("modw_dbz_neg", OP_MOD, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C);
        runOp("divwu_dbz", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        runOp("modwu_dbz", OP_MODU, 32'h1234_5678, 32'd0, 32'h1234_5678);

        // Flush in CALC iteration 10: back to idle, no done, result held.
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        checkOutput("flush_ready", {31'b0, div_ready}, 32'd1);
        checkOutput("flush_result_held", div_result, 32'h1234_5678);
        seen = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (div_done) seen = 1;
        end
        checkOutput("flush_no_done", 32'(seen), 32'd0);
        runOp("divwu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

        // A flush together with valid in idle must not start an op.
        @(negedge clk);
        div_valid = 1'b1;
        div_flush = 1'b1;
        div_op    = OP_DIV;
        div_src1  = 32'd50;
        div_src2  = 32'd5;
        @(negedge clk);
        div_valid = 1'b0;
        div_flush = 1'b0;
        checkOutput("flush_valid_no_accept", {31'b0, div_ready}, 32'd1);

        // Asynchronous reset mid-CALC, off a clock edge.
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_ready", {31'b0, div_ready}, 32'd1);
        checkOutput("async_reset_done", {31'b0, div_done}, 32'd0);
        checkOutput("async_reset_result", div_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        runOp("modw_100_7_after_reset", OP_MOD, 32'd100, 32'd7, 32'd2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
